muldiv_unit: RTL and testbench

- Parametrised RISC-V M-extension execute unit: multiply, divide and remainder for any even XLEN.
- Sits beside the integer ALU in the execute stage and drives the pipeline-stall request.
- Valid/ready handshakes on request and response; one operation in flight.
- Pipelined multiplier with configurable latency; iterative one-bit-per-cycle divider.
- DIV/REM pairs on identical operands are served from a remainder/quotient cache.

---
 rtl/muldiv_unit_pkg.sv | 47 ++++
 rtl/muldiv_div_core.sv | 65 ++++++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: funct3 codes,
// FSM state encodings and small decode helpers.
package muldiv_unit_pkg;

  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;

  localparam logic [2:0] MD_ST_IDLE = 3'd0;
  localparam logic [2:0] MD_ST_MUL  = 3'd1;
  localparam logic [2:0] MD_ST_DIV  = 3'd2;
  localparam logic [2:0] MD_ST_FIX  = 3'd3;
  localparam logic [2:0] MD_ST_DONE = 3'd4;

  // Operand width after sign/zero extension for the multiplier.
  function automatic int mdExtWidth(input int xlen);
    return xlen + 1;
  endfunction

  function automatic logic mdIsDiv(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU) ||
           (op == MD_OP_REM) || (op == MD_OP_REMU);
  endfunction

  function automatic logic mdDivSigned(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  function automatic logic mdWantsQuotient(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  // MUL takes the low half, so its operand signedness is irrelevant.
  function automatic logic mdMulSignA(input logic [2:0] op);
    return op != MD_OP_MULHU;
  endfunction

  function automatic logic mdMulSignB(input logic [2:0] op);
    return (op == MD_OP_MULH) || (op == MD_OP_MUL);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on operand magnitudes: one quotient bit per
// cycle, XLEN cycles after start. Sign correction is left to the caller.
module muldiv_div_core
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  quo_q, rem_q, divisor_q;
  logic [XLEN-1:0]  aMag, bMag;
  logic [XLEN:0]    shifted, trial;

  assign aMag = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
  assign bMag = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;

  // Remainder stays below the divisor, so the shifted value is under twice
  // the divisor and the top bit of trial is a reliable borrow flag.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, divisor_q};

  // done marks the edge on which the final iteration is written.
  assign done_o      = (cnt_q == CNT_W'(1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      cnt_q     <= CNT_W'(XLEN);
      quo_q     <= aMag;
      rem_q     <= '0;
      divisor_q <= bMag;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (!trial[XLEN]) begin
        rem_q <= trial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension execute unit: pipelined multiplier, iterative divider,
// divide special-case shortcuts and a single-entry quotient/remainder cache.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int EXT_W = mdExtWidth(XLEN);
  localparam int PRD_W = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [TAG_W-1:0] tag_q;
  logic [1:0]       mulCnt_q;
  logic             divSetup_q, fixPre_q;
  logic [XLEN-1:0]  preQuo_q, preRem_q, resData_q;
  logic             cacheValid_q, cacheSigned_q;
  logic [XLEN-1:0]  cacheA_q, cacheB_q, cacheQuo_q, cacheRem_q;

  logic             reqReady, accept, reqSigned, reqHit, reqZero, reqOvf, reqShort;
  logic [XLEN-1:0]  reqPreQuo, reqPreRem;
  logic [EXT_W-1:0] aExt, bExt;
  logic [PRD_W-1:0] aWide, bWide, productComb, mulFinal;
  logic [XLEN-1:0]  mulResult;
  logic             divStart, coreDone, negQuo, negRem;
  logic [XLEN-1:0]  coreQuo, coreRem, fixQuo, fixRem;

  assign reqReady   = (state_q == MD_ST_IDLE) && !flush;
  assign req_ready  = reqReady;
  assign accept     = req_valid && reqReady;
  assign resp_valid = (state_q == MD_ST_DONE);
  assign busy       = (state_q != MD_ST_IDLE);
  assign resp_data  = resData_q;
  assign resp_tag   = tag_q;

  // Divide shortcuts are resolved at accept time so they finish in one cycle.
  assign reqSigned = mdDivSigned(req_op);
  assign reqHit    = cacheValid_q && (req_a == cacheA_q) && (req_b == cacheB_q) &&
                     (reqSigned == cacheSigned_q);
  assign reqZero   = (req_b == '0);
  assign reqOvf    = reqSigned && (req_a == MIN_VAL) && (req_b == '1);
  assign reqShort  = reqHit || reqZero || reqOvf;
  assign reqPreQuo = reqHit ? cacheQuo_q : (reqZero ? '1 : req_a);
  assign reqPreRem = reqHit ? cacheRem_q : (reqZero ? req_a : '0);

  // Bits above 2*XLEN of the extended product never reach a result.
  assign aExt        = {mdMulSignA(op_q) & a_q[XLEN-1], a_q};
  assign bExt        = {mdMulSignB(op_q) & b_q[XLEN-1], b_q};
  assign aWide       = {{(PRD_W-EXT_W){aExt[EXT_W-1]}}, aExt};
  assign bWide       = {{(PRD_W-EXT_W){bExt[EXT_W-1]}}, bExt};
  assign productComb = aWide * bWide;

  generate
    if (MUL_STAGES == 1) begin : g_mulComb
      assign mulFinal = productComb;
    end else begin : g_mulPipe
      logic [PRD_W-1:0] pipe_q [MUL_STAGES-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= productComb;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign mulFinal = pipe_q[MUL_STAGES-2];
    end
  endgenerate

  assign mulResult = (op_q == MD_OP_MUL) ? mulFinal[XLEN-1:0] : mulFinal[PRD_W-1:XLEN];

  assign divStart = (state_q == MD_ST_DIV) && divSetup_q;

  muldiv_div_core #(.XLEN(XLEN)) u_divCore (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .start_i     (divStart),
    .signed_i    (mdDivSigned(op_q)),
    .a_i         (a_q),
    .b_i         (b_q),
    .quotient_o  (coreQuo),
    .remainder_o (coreRem),
    .done_o      (coreDone)
  );

  assign negQuo = mdDivSigned(op_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
  assign negRem = mdDivSigned(op_q) && a_q[XLEN-1];
  assign fixQuo = fixPre_q ? preQuo_q : (negQuo ? -coreQuo : coreQuo);
  assign fixRem = fixPre_q ? preRem_q : (negRem ? -coreRem : coreRem);

  // Flush overrides every transition, including a DONE handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_ST_IDLE: if (accept)
                    state_d = !mdIsDiv(req_op) ? MD_ST_MUL :
                              (reqShort ? MD_ST_FIX : MD_ST_DIV);
      MD_ST_MUL:  if (mulCnt_q == 2'd0) state_d = MD_ST_DONE;
      MD_ST_DIV:  if (coreDone) state_d = MD_ST_FIX;
      MD_ST_FIX:  state_d = MD_ST_DONE;
      MD_ST_DONE: if (resp_ready) state_d = MD_ST_IDLE;
      default:    state_d = MD_ST_IDLE;
    endcase
    if (flush) state_d = MD_ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MD_ST_IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      tag_q         <= '0;
      mulCnt_q      <= '0;
      divSetup_q    <= 1'b0;
      fixPre_q      <= 1'b0;
      preQuo_q      <= '0;
      preRem_q      <= '0;
      resData_q     <= '0;
      cacheValid_q  <= 1'b0;
      cacheSigned_q <= 1'b0;
      cacheA_q      <= '0;
      cacheB_q      <= '0;
      cacheQuo_q    <= '0;
      cacheRem_q    <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        cacheValid_q <= 1'b0;
        divSetup_q   <= 1'b0;
      end else begin
        if (accept) begin
          op_q       <= req_op;
          a_q        <= req_a;
          b_q        <= req_b;
          tag_q      <= req_tag;
          mulCnt_q   <= 2'(MUL_STAGES - 1);
          divSetup_q <= mdIsDiv(req_op) && !reqShort;
          fixPre_q   <= reqShort;
          preQuo_q   <= reqPreQuo;
          preRem_q   <= reqPreRem;
        end
        if (divStart) divSetup_q <= 1'b0;
        if (state_q == MD_ST_MUL) begin
          if (mulCnt_q == 2'd0) resData_q <= mulResult;
          else                  mulCnt_q  <= mulCnt_q - 2'd1;
        end
        if (state_q == MD_ST_FIX) begin
          resData_q     <= mdWantsQuotient(op_q) ? fixQuo : fixRem;
          cacheValid_q  <= 1'b1;
          cacheSigned_q <= mdDivSigned(op_q);
          cacheA_q      <= a_q;
          cacheB_q      <= b_q;
          cacheQuo_q    <= fixQuo;
          cacheRem_q    <= fixRem;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam int COMPUTED_DIV_LAT = 34;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model of the single-entry cache, tracked at operation level.
  bit          mCacheValid = 1'b0;
  logic [31:0] mA, mB;
  bit          mSigned;

  muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                 else return 32'(sa / sb);
      OP_DIVU:   if (b == 0) return 32'hFFFF_FFFF; else return 32'(ua / ub);
      OP_REM:    if (b == 0) return a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                 else return 32'(sa % sb);
      default:   if (b == 0) return a; else return 32'(ua % ub);
    endcase
  endfunction

  function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn, hit, special;
    if (!op[2]) return 2;
    sgn     = (op == OP_DIV) || (op == OP_REM);
    hit     = mCacheValid && (a == mA) && (b == mB) && (sgn == mSigned);
    special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (hit || special) ? 1 : COMPUTED_DIV_LAT;
  endfunction

  // Issues one request from IDLE, measures accept-to-valid latency, then handshakes.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output logic [31:0] data, output logic [4:0] rtag,
                       output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!resp_valid && lat < TIMEOUT);
    if (!resp_valid) begin
      checks++; errors++;
      $display("[TB] FAIL timeout: op %0d got no resp_valid within %0d cycles", op, TIMEOUT);
    end
    data = resp_data;
    rtag = resp_tag;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    if (op[2]) begin
      mCacheValid = 1'b1; mA = a; mB = b; mSigned = (op == OP_DIV) || (op == OP_REM);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_data: got %h expected 0", resp_data); end
    checks++; if (resp_tag !== 5'h0) begin errors++; $display("[TB] FAIL reset_resp_tag: got %h expected 0", resp_tag); end
    @(negedge clk); rst_n = 1'b1;
    mCacheValid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_mulh();
    logic [31:0] d; logic [4:0] t; int lat;
    runOp(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, d, t, lat);
    checks++; if (d !== 32'h4000_0000) begin errors++; $display("[TB] FAIL mulh_data: got %h expected 40000000", d); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL mulh_latency: got %0d expected 2", lat); end
    runOp(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, d, t, lat);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mulhu_data: got %h expected fffffffe", d); end
    runOp(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, d, t, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mulhsu_data: got %h expected ffffffff", d); end
  endtask

  task automatic test_random_mul();
    logic [31:0] d, a, b, exp; logic [4:0] t, tag; logic [2:0] op; int lat;
    for (int i = 0; i < 16; i++) begin
      op  = 3'($urandom_range(0, 3));
      a   = (i == 0) ? 32'h8000_0000 : $urandom;
      b   = (i == 1) ? 32'hFFFF_FFFF : $urandom;
      tag = 5'($urandom);
      exp = refModel(op, a, b);
      runOp(op, a, b, tag, d, t, lat);
      checks++; if (d !== exp) begin errors++; $display("[TB] FAIL rand_mul_data: op %0d a %h b %h got %h expected %h", op, a, b, d, exp); end
      checks++; if (t !== tag) begin errors++; $display("[TB] FAIL rand_mul_tag: got %h expected %h", t, tag); end
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL rand_mul_latency: got %0d expected 2", lat); end
    end
  endtask

  task automatic test_div_cache();
    logic [31:0] d; logic [4:0] t; int lat;
    runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, d, t, lat);
    checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_data: got %h expected fffffffd", d); end
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 34", lat); end
    runOp(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, d, t, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL rem_hit_data: got %h expected ffffffff", d); end
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL rem_hit_latency: got %0d expected 1", lat); end
    runOp(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd6, d, t, lat);
    checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL remu_data: got %h expected 1", d); end
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL remu_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_special();
    logic [31:0] d; logic [4:0] t; int lat;
    runOp(OP_DIVU, 32'h1234, 32'h0, 5'd7, d, t, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divu_zero_data: got %h expected ffffffff", d); end
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL divu_zero_latency: got %0d expected 1", lat); end
    runOp(OP_REM, 32'h1234, 32'h0, 5'd8, d, t, lat);
    checks++; if (d !== 32'h1234) begin errors++; $display("[TB] FAIL rem_zero_data: got %h expected 1234", d); end
    runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, d, t, lat);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("[TB] FAIL div_ovf_data: got %h expected 80000000", d); end
    checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL div_ovf_latency: got %0d expected 1", lat); end
    runOp(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, d, t, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL rem_ovf_data: got %h expected 0", d); end
  endtask

  task automatic test_random_div();
    logic [31:0] d, a, b, exp, prevA, prevB; logic [4:0] t; logic [2:0] op; int lat, expLat;
    prevA = 32'd100; prevB = 32'd9;
    for (int i = 0; i < 16; i++) begin
      op = 3'(4 + $urandom_range(0, 3));
      case (i % 4)
        0:       begin a = $urandom; b = 32'h0; end
        1:       begin a = $urandom; b = 32'($urandom_range(1, 50)); end
        2:       begin a = prevA; b = prevB; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if (i == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i == 7) begin a = 32'hFFFF_FF00; b = 32'hFFFF_FFF3; end
      exp    = refModel(op, a, b);
      expLat = expLatency(op, a, b);
      runOp(op, a, b, 5'(i), d, t, lat);
      checks++; if (d !== exp) begin errors++; $display("[TB] FAIL rand_div_data: op %0d a %h b %h got %h expected %h", op, a, b, d, exp); end
      checks++; if (lat !== expLat) begin errors++; $display("[TB] FAIL rand_div_latency: op %0d got %0d expected %0d", op, lat, expLat); end
      prevA = a; prevB = b;
    end
  endtask

  task automatic test_backpressure();
    int lat, handshakes;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd7; req_b = 32'd6; req_tag = 5'd21; resp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < TIMEOUT) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 2", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'd42 || resp_tag !== 5'd21 || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold: cycle %0d valid %b data %0d tag %0d req_ready %b, expected 1/42/21/0",
                 i, resp_valid, resp_data, resp_tag, req_ready);
      end
    end
    handshakes = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      if (resp_valid && resp_ready) handshakes++;
      #1 resp_ready = 1'b1;
    end
    resp_ready = 1'b0;
    checks++; if (handshakes !== 1) begin errors++; $display("[TB] FAIL bp_handshakes: got %0d expected 1", handshakes); end
  endtask

  task automatic test_flush();
    logic [31:0] d; logic [4:0] t; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'hFFFF_FF9C; req_b = 32'd7; req_tag = 5'd11;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd3; req_b = 32'd3; req_tag = 5'd12;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_req_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
    mCacheValid = 1'b0;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle: busy %b resp_valid %b expected 0/0", busy, resp_valid); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_accept: busy %b resp_valid %b expected 0/0", busy, resp_valid); end
    runOp(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd13, d, t, lat);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL flush_rem_data: got %h expected fffffffe", d); end
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL flush_rem_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] d; logic [4:0] t; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd17;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_tag !== 5'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: busy %b valid %b data %h tag %h expected all 0", busy, resp_valid, resp_data, resp_tag);
    end
    @(negedge clk); rst_n = 1'b1;
    mCacheValid = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_req_ready: got %b expected 1", req_ready); end
    runOp(OP_DIVU, 32'd1000, 32'd3, 5'd18, d, t, lat);
    checks++; if (d !== 32'd333) begin errors++; $display("[TB] FAIL rst_mid_div_data: got %0d expected 333", d); end
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL rst_mid_div_latency: got %0d expected 34", lat); end
  endtask

  initial begin
    test_reset();
    test_mulh();
    test_random_mul();
    test_div_cache();
    test_special();
    test_random_div();
    test_backpressure();
    test_flush();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
